// File: rtl/bundler_ctrl_if.sv
// Control-side handshake bundle between the HV encoder stream, the
// bundler_set datapath and the result consumer.
//   slave  : the bundler_ctrl side (receives start/abort/hv_valid/result_ready)
//   master : the driving environment (issues jobs, feeds HVs, consumes results)
// Signal names keep their _i/_o suffixes as seen from bundler_ctrl.
interface bundler_ctrl_if #(
  parameter int NumItemWidth = 8
);
  logic                    start_i;
  logic [NumItemWidth-1:0] num_items_i;
  logic                    abort_i;
  logic                    hv_valid_i;
  logic                    hv_ready_o;
  logic                    bundle_valid_o;
  logic                    bundle_clr_o;
  logic                    result_valid_o;
  logic                    result_ready_i;
  logic                    busy_o;
  logic                    err_o;
  logic [NumItemWidth-1:0] count_o;

  modport slave (
    input  start_i, num_items_i, abort_i, hv_valid_i, result_ready_i,
    output hv_ready_o, bundle_valid_o, bundle_clr_o, result_valid_o,
           busy_o, err_o, count_o
  );

  modport master (
    output start_i, num_items_i, abort_i, hv_valid_i, result_ready_i,
    input  hv_ready_o, bundle_valid_o, bundle_clr_o, result_valid_o,
           busy_o, err_o, count_o
  );
endinterface

// File: rtl/bundler_ctrl.sv
// Sequences one bundling job on a bundler_set datapath: clears the set's
// counters, gates num_items accepted HVs into its valid input, then holds the
// result until the consumer takes it.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : bundler_ctrl_if.slave (job control, HV stream, result handshake,
//            bundler_set valid/clr, status busy/err/count)
//
// state  | meaning
// IDLE   | waiting for start_i; previous result stays readable in the set
// CLEAR  | one cycle clearing the bundler_set counters and count
// ACCUM  | accepting HVs until target have been taken
// OUTPUT | result_valid_o asserted until result_ready_i
module bundler_ctrl #(
  parameter int CounterWidth = 8,
  parameter int NumItemWidth = 8,
  parameter int MaxItems     = 2**(CounterWidth-1)-1
) (
  input logic          clk_i,
  input logic          rst_ni,
  bundler_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    ACCUM  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  localparam logic [31:0] MaxItemsW = 32'(MaxItems);

  state_t                  state_q, state_d;
  logic [NumItemWidth-1:0] count_q, count_d;
  logic [NumItemWidth-1:0] target_q, target_d;
  logic                    err_q, err_d;

  logic hv_ready, bundle_valid, bundle_clr, result_valid;
  logic num_ok;

  // Upper bound keeps the signed bundler counters from overflowing.
  assign num_ok = (bus.num_items_i != '0) && (32'(bus.num_items_i) <= MaxItemsW);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      count_q  <= '0;
      target_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    target_d     = target_q;
    err_d        = 1'b0;
    hv_ready     = 1'b0;
    bundle_valid = 1'b0;
    bundle_clr   = 1'b0;
    result_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (num_ok) begin
            target_d = bus.num_items_i;
            state_d  = CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      CLEAR: begin
        bundle_clr = 1'b1;
        count_d    = '0;
        state_d    = bus.abort_i ? IDLE : ACCUM;
      end

      ACCUM: begin
        if (bus.abort_i) begin
          bundle_clr = 1'b1;
          count_d    = '0;
          state_d    = IDLE;
        end else begin
          hv_ready = 1'b1;
          if (bus.hv_valid_i) begin
            bundle_valid = 1'b1;
            count_d      = count_q + 1'b1;
            // Leave on the edge that registers the last item, so the set is
            // final by the time result_valid_o rises.
            if (count_q == target_q - 1'b1) state_d = OUTPUT;
          end
        end
      end

      OUTPUT: begin
        if (bus.abort_i) begin
          bundle_clr = 1'b1;
          count_d    = '0;
          state_d    = IDLE;
        end else begin
          result_valid = 1'b1;
          if (bus.result_ready_i) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.hv_ready_o     = hv_ready;
  assign bus.bundle_valid_o = bundle_valid;
  assign bus.bundle_clr_o   = bundle_clr;
  assign bus.result_valid_o = result_valid;
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.err_o          = err_q;
  assign bus.count_o        = count_q;

endmodule

// File: tb/tb_bundler_ctrl.sv
// Scoreboard bench for bundler_ctrl. A behavioural bundler_set (per-bit
// signed vote counters driven by the DUT's clr/valid) produces the result
// the monitor compares with the majority computed directly from the HVs
// handed to each job.
module tb_bundler_ctrl;
  localparam int CW   = 8;
  localparam int NW   = 8;
  localparam int HVW  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bundler_ctrl_if #(.NumItemWidth(NW)) bus ();

  bundler_ctrl #(.CounterWidth(CW), .NumItemWidth(NW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct {
    int             n;
    logic [HVW-1:0] maj;
  } res_t;

  res_t           exp_q[$];
  int             err_exp = 0;
  int             errors  = 0;
  int             checks  = 0;
  logic [HVW-1:0] cur_hvs[$];
  logic [HVW-1:0] hv_data = '0;
  int             job_sent = 0;

  task automatic chk(string name, longint act, longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Behavioural bundler_set: +1 for a 1 bit, -1 for a 0 bit; binarized = count>0.
  int acc [HVW];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < HVW; b++) acc[b] = 0;
    end else if (bus.bundle_clr_o) begin
      for (int b = 0; b < HVW; b++) acc[b] = 0;
    end else if (bus.bundle_valid_o) begin
      for (int b = 0; b < HVW; b++) acc[b] = acc[b] + (hv_data[b] ? 1 : -1);
    end
  end

  function automatic logic [HVW-1:0] model_bin();
    logic [HVW-1:0] r;
    for (int b = 0; b < HVW; b++) r[b] = (acc[b] > 0);
    return r;
  endfunction

  // Monitor
  logic prev_rv = 1'b0;
  int   hold_n  = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.err_o) begin
        checks++;
        if (err_exp == 0) begin
          errors++;
          $display("FAIL unexpected_err: err_o=1 expected 0 at %0t", $time);
        end else begin
          err_exp--;
        end
      end
      if (bus.result_valid_o && !prev_rv) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: result_valid_o=1 with no job pending at %0t", $time);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          hold_n = e.n;
          chk("result_count", bus.count_o, e.n);
          chk("result_bits", model_bin(), e.maj);
        end
      end else if (bus.result_valid_o) begin
        chk("result_hold_count", bus.count_o, hold_n);
      end
      prev_rv = bus.result_valid_o;
    end else begin
      prev_rv = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(int n);
    cur_hvs.delete();
    for (int i = 0; i < n; i++) cur_hvs.push_back(HVW'($urandom));
  endtask

  task automatic push_expected(int n);
    res_t e;
    e.n = n;
    for (int b = 0; b < HVW; b++) begin
      int ones = 0;
      for (int i = 0; i < n; i++) ones += cur_hvs[i][b] ? 1 : 0;
      e.maj[b] = (2 * ones > n);
    end
    exp_q.push_back(e);
  endtask

  task automatic start_job(int n);
    bus.start_i     = 1'b1;
    bus.num_items_i = NW'(n);
    cyc();
    bus.start_i     = 1'b0;
    job_sent        = 0;
  endtask

  // mode 0: hv_valid held, 1: toggled 1010..., 2: random
  task automatic send_items(int k, int mode, bit poke);
    int budget = 0;
    int sent   = 0;
    while (sent < k && budget < 2000) begin
      case (mode)
        0:       bus.hv_valid_i = 1'b1;
        1:       bus.hv_valid_i = (budget % 2 == 0);
        default: bus.hv_valid_i = 1'($urandom_range(0, 1));
      endcase
      hv_data = cur_hvs[job_sent];
      if (poke && sent == 1) begin
        bus.start_i     = 1'b1;
        bus.num_items_i = (budget % 2 == 1) ? NW'(0) : NW'(2);
      end else begin
        bus.start_i = 1'b0;
      end
      @(negedge clk);
      if (budget == 0) begin
        chk("clr_cycle", bus.bundle_clr_o, 1);
        chk("no_ready_in_clear", bus.hv_ready_o, 0);
      end else if (budget == 1) begin
        chk("clr_one_cycle", bus.bundle_clr_o, 0);
        chk("ready_latency", bus.hv_ready_o, 1);
      end
      if (bus.hv_ready_o) begin
        chk("count_step", bus.count_o, job_sent);
        chk("bundle_valid", bus.bundle_valid_o, bus.hv_valid_i ? 1 : 0);
      end
      if (bus.hv_valid_i && bus.hv_ready_o) begin
        sent++;
        job_sent++;
      end
      cyc();
      budget++;
    end
    bus.hv_valid_i = 1'b0;
    bus.start_i    = 1'b0;
    if (budget >= 2000) chk("accum_timeout", sent, k);
  endtask

  task automatic finish_result(int delay, bit poke);
    int budget = 0;
    @(negedge clk);
    while (!bus.result_valid_o && budget < 50) begin
      cyc();
      @(negedge clk);
      budget++;
    end
    chk("result_seen", bus.result_valid_o, 1);
    cyc();
    for (int i = 0; i < delay; i++) begin
      if (poke && i == 0) begin
        bus.start_i     = 1'b1;
        bus.num_items_i = NW'(0);
      end
      @(negedge clk);
      chk("result_held", bus.result_valid_o, 1);
      cyc();
      bus.start_i = 1'b0;
    end
    bus.result_ready_i = 1'b1;
    @(negedge clk);
    chk("result_at_ready", bus.result_valid_o, 1);
    cyc();
    bus.result_ready_i = 1'b0;
    @(negedge clk);
    chk("idle_after_ready", bus.busy_o, 0);
    chk("no_result_after_ready", bus.result_valid_o, 0);
    cyc();
  endtask

  task automatic run_prepared(int n, int mode, int delay, bit poke);
    push_expected(n);
    start_job(n);
    send_items(n, mode, poke);
    finish_result(delay, poke);
  endtask

  task automatic reject(int n);
    err_exp++;
    start_job(n);
    @(negedge clk);
    chk("reject_busy", bus.busy_o, 0);
    chk("reject_err", bus.err_o, 1);
    cyc();
    @(negedge clk);
    chk("err_one_cycle", bus.err_o, 0);
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i        = 1'b0;
    bus.num_items_i    = '0;
    bus.abort_i        = 1'b0;
    bus.hv_valid_i     = 1'b0;
    bus.result_ready_i = 1'b0;
    #3;
    chk("rst_outputs", {bus.hv_ready_o, bus.bundle_valid_o, bus.bundle_clr_o,
                        bus.result_valid_o, bus.busy_o, bus.err_o}, 0);
    chk("rst_count", bus.count_o, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Basic job: HVs FF,FF,00 -> every bit votes 1.
    cur_hvs.delete();
    cur_hvs.push_back(8'hFF);
    cur_hvs.push_back(8'hFF);
    cur_hvs.push_back(8'h00);
    run_prepared(3, 0, 0, 1'b0);

    // Bubbles and backpressure.
    fill_random(4);
    run_prepared(4, 1, 5, 1'b0);

    // Rejects.
    reject(0);
    reject(128);
    reject(255);

    // Largest legal job.
    fill_random(127);
    run_prepared(127, 0, 0, 1'b0);

    // Abort after 2 of 5, then a 1-HV job.
    fill_random(5);
    start_job(5);
    send_items(2, 0, 1'b0);
    bus.abort_i    = 1'b1;
    bus.hv_valid_i = 1'b1;
    @(negedge clk);
    chk("abort_clr", bus.bundle_clr_o, 1);
    chk("abort_ready", bus.hv_ready_o, 0);
    chk("abort_bundle_valid", bus.bundle_valid_o, 0);
    chk("abort_result_valid", bus.result_valid_o, 0);
    cyc();
    bus.abort_i    = 1'b0;
    bus.hv_valid_i = 1'b0;
    @(negedge clk);
    chk("abort_idle", bus.busy_o, 0);
    chk("abort_count", bus.count_o, 0);
    cyc();
    fill_random(1);
    run_prepared(1, 0, 1, 1'b0);

    // Abort in IDLE does nothing.
    bus.abort_i = 1'b1;
    @(negedge clk);
    chk("idle_abort_clr", bus.bundle_clr_o, 0);
    cyc();
    bus.abort_i = 1'b0;

    // start_i while busy is ignored.
    fill_random(6);
    run_prepared(6, 0, 3, 1'b1);

    // Reset mid-ACCUM.
    fill_random(5);
    start_job(5);
    send_items(2, 0, 1'b0);
    bus.hv_valid_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {bus.hv_ready_o, bus.bundle_valid_o, bus.bundle_clr_o,
                           bus.result_valid_o, bus.busy_o, bus.err_o}, 0);
    chk("midrst_count", bus.count_o, 0);
    bus.hv_valid_i = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    fill_random(3);
    run_prepared(3, 2, 2, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 12; j++) begin
      int n;
      n = $urandom_range(1, 12);
      fill_random(n);
      run_prepared(n, $urandom_range(0, 2), $urandom_range(0, 3),
                   (n >= 4) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    repeat (3) cyc();
    chk("results_outstanding", exp_q.size(), 0);
    chk("err_outstanding", err_exp, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
